mc_control_fsm: RTL and testbench
=================================

// Module: mc_control_fsm
// PURPOSE
//  Main control state machine of the multicycle MIPS core. Sequences PC/IR/regfile/memory writes,
//  ALU operand muxes and the immediate extender's ExtCtrl for each instruction. Sits between IR
//  opcode/funct and all datapath control inputs. Also has a memory handshake with a wait timeout.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max consecutive wait cycles on mem_ready before fault (1..255)
// PORTS
//  clk        in   1  clock, rising edge
//  rst_n      in   1  asynchronous, active-low reset
//  opcode     in   6  IR[31:26]; valid from the cycle after IRWrite
//  funct      in   6  IR[5:0]
//  zero       in   1  ALU zero flag (combinational, same cycle)
//  mem_ready  in   1  memory completes the current request this cycle
//  mem_req    out  1  memory access request; mem_we=1 write, 0 read
//  mem_we     out  1
//  IorD       out  1  0=PC address, 1=ALUOut address
//  PCWrite    out  1  PC load enable
//  PCSrc      out  2  00 ALU result, 01 ALUOut (branch), 10 jump target
//  IRWrite    out  1  IR load enable
//  ExtCtrl    out  1  1=sign-extend imm16, 0=zero-extend
//  ALUSrcA    out  1  0=PC, 1=rs
//  ALUSrcB    out  2  00 rt, 01 const 4, 10 ext imm, 11 ext imm<<2
//  ALUOp      out  3  000 ADD, 001 SUB, 010 FUNCT, 011 AND, 100 OR, 101 SLT
//  RegWrite   out  1  regfile write enable
//  RegDst     out  2  00 rt, 01 rd, 10 $31
//  MemToReg   out  2  00 ALUOut, 01 MDR, 10 PC
//  halted     out  1  sticky: HALT instruction or timeout reached
//  fault      out  1  sticky: memory timeout (implies halted)
//  illegal    out  1  one-cycle pulse in ID on unknown opcode
// BEHAVIOUR
//  - Reset (async): state=IF, wait counter=0, halted=fault=0. Moore outputs, decoded from state
//    and opcode: all enables 0 outside their states. Release takes effect at the next clk edge.
//  - States: IF, ID, EXE_R, EXE_I, EXE_MA, EXE_BR, EXE_J, MEM_RD, MEM_WR, WB_R, WB_I, WB_LD, HALT.
//  - IF: mem_req=1, IorD=0. ALUSrcA=0, ALUSrcB=01, ADD. IRWrite=PCWrite=mem_ready, PCSrc=00.
//    Stays in IF until mem_ready, then goes to ID.
//  - ID: ALUSrcA=0, ALUSrcB=11, ADD (branch target to ALUOut). Next state by opcode:
//    000000 EXE_R; 001000/001001/001010/001100/001101 EXE_I; 100011/101011 EXE_MA;
//    000100/000101 EXE_BR; 000010/000011 EXE_J; 111111 HALT; other -> IF with illegal=1.
//  - EXE_R: A=rs, B=rt, ALUOp=FUNCT, then WB_R. WB_R: RegWrite, RegDst=01, MemToReg=00, then IF.
//  - EXE_I: A=rs, B=imm. ALUOp ADD (addi/addiu), SLT (slti), AND (andi), OR (ori), then WB_I.
//    WB_I: RegWrite, RegDst=00, MemToReg=00, then IF.
//  - EXE_MA: rs+imm, ADD, then MEM_RD (lw) or MEM_WR (sw).
//  - MEM_RD / MEM_WR: mem_req=1, IorD=1, mem_we=0/1, held until mem_ready.
//    MEM_RD then WB_LD (RegWrite, RegDst=00, MemToReg=01), then IF. MEM_WR then IF.
//  - EXE_BR: rs-rt, SUB. PCWrite = zero (beq) or ~zero (bne), PCSrc=01, then IF.
//  - EXE_J: PCWrite=1, PCSrc=10. jal adds RegWrite, RegDst=10, MemToReg=10 (PC already +4).
//    Then IF.
//  - ExtCtrl=0 for andi/ori, 1 for every other opcode. It is held constant from ID to the end of
//    the instruction. In IF it takes the previous opcode's value (don't-care).
//  - Latency without waits: R/I 4, lw 5, sw 4, beq/bne/j/jal 3 cycles.
//    Each mem_ready-low cycle adds 1 cycle.
//  - Wait counter: cleared on entry to any memory state and when mem_ready=1.
//    +1 per cycle in a memory state with mem_ready=0. When it reaches TIMEOUT_CYCLES:
//    go to HALT, fault=1, mem_req drops.
//  - HALT: all enables 0, halted=1. Only reset exits. mem_ready is ignored outside memory states.
//  - Reset mid-instruction: the in-flight access is abandoned (mem_req drops asynchronously).
//    No partial register or PC write happens.
// STRUCTURE
//  - Package mc_ctrl_pkg: state enum encoding, opcode/funct localparams, ALUOp/PCSrc/ALUSrcB/
//    RegDst/MemToReg codes, shared with datapath and bench.
//  - One sub-module mc_ctrl_decode: combinational opcode -> {class, ExtCtrl, I-type ALUOp}.
//    The FSM holds only the state register and the wait counter.
// TESTING
//  - add $3,$1,$2 with mem_ready=1: states IF,ID,EXE_R,WB_R. ALUOp=010 in cycle 3.
//    RegWrite/RegDst=01 only in cycle 4.
//  - ori (0x0D) then addi (0x08): ExtCtrl=0 for ID..WB of ori, then 1 for ID..WB of addi.
//    ALUOp=100 then 000.
//  - lw with mem_ready low 3 cycles in MEM_RD: 8 cycles total. mem_req,IorD=1 for 4 cycles.
//    WB_LD MemToReg=01.
//  - beq zero=1 -> PCWrite=1,PCSrc=01 in cycle 3. bne zero=1 -> PCWrite=0. jal -> RegDst=10,
//    MemToReg=10.
//  - mem_ready stuck 0 in IF, TIMEOUT_CYCLES=4: HALT after 4 wait cycles, fault=halted=1.
//    Only rst_n low clears them.
//  - Opcode 0x3E -> illegal pulse 1 cycle, back to IF. rst_n low in MEM_WR -> immediate
//    mem_req=0, state IF.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path.
// Imported by the control FSM, its decoder, the datapath and the bench.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IF,
    S_ID,
    S_EXE_R,
    S_EXE_I,
    S_EXE_MA,
    S_EXE_BR,
    S_EXE_J,
    S_MEM_RD,
    S_MEM_WR,
    S_WB_R,
    S_WB_I,
    S_WB_LD,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    CL_R,
    CL_I,
    CL_MA,
    CL_BR,
    CL_J,
    CL_HALT,
    CL_ILL
  } iclass_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;

  localparam logic [1:0] PC_ALU  = 2'b00;
  localparam logic [1:0] PC_BR   = 2'b01;
  localparam logic [1:0] PC_JMP  = 2'b10;

  localparam logic [1:0] SB_RT   = 2'b00;
  localparam logic [1:0] SB_FOUR = 2'b01;
  localparam logic [1:0] SB_IMM  = 2'b10;
  localparam logic [1:0] SB_IMM4 = 2'b11;

  localparam logic [1:0] RD_RT   = 2'b00;
  localparam logic [1:0] RD_RD   = 2'b01;
  localparam logic [1:0] RD_RA   = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MDR = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Opcode classifier: instruction class, extender mode and
// the ALU operation used by immediate arithmetic.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output iclass_t    cls,
  output logic       ext_ctrl,
  output logic [2:0] imm_op
);

  always_comb begin
    cls      = CL_ILL;
    ext_ctrl = 1'b1;
    imm_op   = ALU_ADD;
    unique case (1'b1)
      (opcode == OP_RTYPE): cls = CL_R;
      (opcode == OP_ADDI),
      (opcode == OP_ADDIU): cls = CL_I;
      (opcode == OP_SLTI): begin
        cls    = CL_I;
        imm_op = ALU_SLT;
      end
      (opcode == OP_ANDI): begin
        cls      = CL_I;
        imm_op   = ALU_AND;
        ext_ctrl = 1'b0;
      end
      (opcode == OP_ORI): begin
        cls      = CL_I;
        imm_op   = ALU_OR;
        ext_ctrl = 1'b0;
      end
      (opcode == OP_LW),
      (opcode == OP_SW): cls = CL_MA;
      (opcode == OP_BEQ),
      (opcode == OP_BNE): cls = CL_BR;
      (opcode == OP_J),
      (opcode == OP_JAL): cls = CL_J;
      (opcode == OP_HALT): cls = CL_HALT;
      default: cls = CL_ILL;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main control FSM with memory wait timeout.
// Outputs are decoded from state and opcode; enables are forced low in reset.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       IorD,
  output logic       PCWrite,
  output logic [1:0] PCSrc,
  output logic       IRWrite,
  output logic       ExtCtrl,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemToReg,
  output logic       halted,
  output logic       fault,
  output logic       illegal
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_nxt;
  logic       fault_q, fault_nxt;
  iclass_t    cls;
  logic       ext_ctrl;
  logic [2:0] imm_op;
  logic       mem_state;
  logic       timeout;

  // funct is resolved by the ALU control when ALUOp=FUNCT
  logic unused_funct;
  assign unused_funct = ^funct;

  mc_ctrl_decode u_decode (
    .opcode   (opcode),
    .cls      (cls),
    .ext_ctrl (ext_ctrl),
    .imm_op   (imm_op)
  );

  assign mem_state = (state == S_IF) ||
                     (state == S_MEM_RD) ||
                     (state == S_MEM_WR);
  assign timeout   = mem_state && !mem_ready &&
                     (wait_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IF;
      wait_cnt <= '0;
      fault_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      fault_q  <= fault_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wait_nxt  = '0;
    fault_nxt = fault_q;
    if (mem_state && !mem_ready) wait_nxt = wait_cnt + 8'd1;
    unique case (state)
      S_IF:     if (mem_ready) state_nxt = S_ID;
      S_ID: begin
        unique case (cls)
          CL_R:    state_nxt = S_EXE_R;
          CL_I:    state_nxt = S_EXE_I;
          CL_MA:   state_nxt = S_EXE_MA;
          CL_BR:   state_nxt = S_EXE_BR;
          CL_J:    state_nxt = S_EXE_J;
          CL_HALT: state_nxt = S_HALT;
          default: state_nxt = S_IF;
        endcase
      end
      S_EXE_R:  state_nxt = S_WB_R;
      S_EXE_I:  state_nxt = S_WB_I;
      S_EXE_MA: state_nxt = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: if (mem_ready) state_nxt = S_WB_LD;
      S_MEM_WR: if (mem_ready) state_nxt = S_IF;
      S_EXE_BR,
      S_EXE_J,
      S_WB_R,
      S_WB_I,
      S_WB_LD:  state_nxt = S_IF;
      default:  state_nxt = S_HALT;
    endcase
    if (timeout) begin
      state_nxt = S_HALT;
      wait_nxt  = '0;
      fault_nxt = 1'b1;
    end
  end

  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    IorD     = 1'b0;
    PCWrite  = 1'b0;
    PCSrc    = PC_ALU;
    IRWrite  = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = SB_RT;
    ALUOp    = ALU_ADD;
    RegWrite = 1'b0;
    RegDst   = RD_RT;
    MemToReg = M2R_ALU;
    // reset abandons any in-flight access without waiting for clk
    if (rst_n) begin
      unique case (state)
        S_IF: begin
          mem_req = 1'b1;
          ALUSrcB = SB_FOUR;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_ID:  ALUSrcB = SB_IMM4;
        S_EXE_R: begin
          ALUSrcA = 1'b1;
          ALUOp   = ALU_FUNCT;
        end
        S_EXE_I: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SB_IMM;
          ALUOp   = imm_op;
        end
        S_EXE_MA: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SB_IMM;
        end
        S_EXE_BR: begin
          ALUSrcA = 1'b1;
          ALUOp   = ALU_SUB;
          PCSrc   = PC_BR;
          PCWrite = (opcode == OP_BEQ) ? zero : !zero;
        end
        S_EXE_J: begin
          PCWrite = 1'b1;
          PCSrc   = PC_JMP;
          if (opcode == OP_JAL) begin
            RegWrite = 1'b1;
            RegDst   = RD_RA;
            MemToReg = M2R_PC;
          end
        end
        S_MEM_RD: begin
          mem_req = 1'b1;
          IorD    = 1'b1;
        end
        S_MEM_WR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          IorD    = 1'b1;
        end
        S_WB_R: begin
          RegWrite = 1'b1;
          RegDst   = RD_RD;
        end
        S_WB_I:  RegWrite = 1'b1;
        S_WB_LD: begin
          RegWrite = 1'b1;
          MemToReg = M2R_MDR;
        end
        default: ;
      endcase
    end
  end

  assign ExtCtrl = ext_ctrl;
  assign halted  = (state == S_HALT);
  assign fault   = fault_q;
  assign illegal = rst_n && (state == S_ID) && (cls == CL_ILL);

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: per-state control vectors,
// extender mode, memory waits, timeout, illegal opcode and reset.
module tb_mc_control_fsm;
  import mc_ctrl_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       IorD;
  logic       PCWrite;
  logic [1:0] PCSrc;
  logic       IRWrite;
  logic       ExtCtrl;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUOp;
  logic       RegWrite;
  logic [1:0] RegDst;
  logic [1:0] MemToReg;
  logic       halted;
  logic       fault;
  logic       illegal;

  int total = 0;
  int bad   = 0;

  mc_control_fsm #(.TIMEOUT_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .opcode    (opcode),
    .funct     (funct),
    .zero      (zero),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .IorD      (IorD),
    .PCWrite   (PCWrite),
    .PCSrc     (PCSrc),
    .IRWrite   (IRWrite),
    .ExtCtrl   (ExtCtrl),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp),
    .RegWrite  (RegWrite),
    .RegDst    (RegDst),
    .MemToReg  (MemToReg),
    .halted    (halted),
    .fault     (fault),
    .illegal   (illegal)
  );

  // {mem_req,mem_we,IorD,PCWrite,PCSrc,IRWrite,
  //  ALUSrcA,ALUSrcB,ALUOp,RegWrite,RegDst,MemToReg}
  logic [17:0] ctl;
  assign ctl = {mem_req, mem_we, IorD, PCWrite, PCSrc, IRWrite,
                ALUSrcA, ALUSrcB, ALUOp, RegWrite, RegDst, MemToReg};

  localparam logic [17:0] E_ZERO =
    {1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,2'b00,3'b000,1'b0,2'b00,2'b00};
  localparam logic [17:0] E_IF_W =
    {1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,2'b01,3'b000,1'b0,2'b00,2'b00};
  localparam logic [17:0] E_IF_R =
    {1'b1,1'b0,1'b0,1'b1,2'b00,1'b1,1'b0,2'b01,3'b000,1'b0,2'b00,2'b00};
  localparam logic [17:0] E_ID =
    {1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,2'b11,3'b000,1'b0,2'b00,2'b00};
  localparam logic [17:0] E_EXR =
    {1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b1,2'b00,3'b010,1'b0,2'b00,2'b00};
  localparam logic [17:0] E_WBR =
    {1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,2'b00,3'b000,1'b1,2'b01,2'b00};
  localparam logic [17:0] E_EXI_OR =
    {1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b1,2'b10,3'b100,1'b0,2'b00,2'b00};
  localparam logic [17:0] E_EXI_ADD =
    {1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b1,2'b10,3'b000,1'b0,2'b00,2'b00};
  localparam logic [17:0] E_WBI =
    {1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,2'b00,3'b000,1'b1,2'b00,2'b00};
  localparam logic [17:0] E_EXMA =
    {1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b1,2'b10,3'b000,1'b0,2'b00,2'b00};
  localparam logic [17:0] E_MRD =
    {1'b1,1'b0,1'b1,1'b0,2'b00,1'b0,1'b0,2'b00,3'b000,1'b0,2'b00,2'b00};
  localparam logic [17:0] E_MWR =
    {1'b1,1'b1,1'b1,1'b0,2'b00,1'b0,1'b0,2'b00,3'b000,1'b0,2'b00,2'b00};
  localparam logic [17:0] E_WBLD =
    {1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,2'b00,3'b000,1'b1,2'b00,2'b01};
  localparam logic [17:0] E_BR_T =
    {1'b0,1'b0,1'b0,1'b1,2'b01,1'b0,1'b1,2'b00,3'b001,1'b0,2'b00,2'b00};
  localparam logic [17:0] E_BR_N =
    {1'b0,1'b0,1'b0,1'b0,2'b01,1'b0,1'b1,2'b00,3'b001,1'b0,2'b00,2'b00};
  localparam logic [17:0] E_JAL =
    {1'b0,1'b0,1'b0,1'b1,2'b10,1'b0,1'b0,2'b00,3'b000,1'b1,2'b10,2'b10};
  localparam logic [17:0] E_J =
    {1'b0,1'b0,1'b0,1'b1,2'b10,1'b0,1'b0,2'b00,3'b000,1'b0,2'b00,2'b00};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    mem_ready = 1'b0;
    zero = 1'b0;
    opcode = 6'h00;
    funct = 6'h00;
    #3;
    total++;
    if (ctl !== E_ZERO) begin
      bad++;
      $display("FAIL rst_ctl got=%h exp=%h", ctl, E_ZERO);
    end
    total++;
    if ({halted, fault, illegal} !== 3'b000) begin
      bad++;
      $display("FAIL rst_flags got=%b exp=000", {halted, fault, illegal});
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic fetch(input logic [5:0] op,
                       input logic [5:0] fn,
                       input int waits);
    for (int i = 0; i < waits; i++) begin
      mem_ready = 1'b0;
      #1;
      total++;
      if (ctl !== E_IF_W) begin
        bad++;
        $display("FAIL if_wait got=%h exp=%h", ctl, E_IF_W);
      end
      nxt();
    end
    mem_ready = 1'b1;
    #1;
    total++;
    if (ctl !== E_IF_R) begin
      bad++;
      $display("FAIL if_ready op=%h got=%h exp=%h", op, ctl, E_IF_R);
    end
    nxt();
    opcode = op;
    funct = fn;
    mem_ready = 1'b0;
    #1;
    total++;
    if ({ctl, illegal} !== {E_ID, 1'b0}) begin
      bad++;
      $display("FAIL id op=%h got=%h/%b exp=%h/0", op, ctl, illegal, E_ID);
    end
  endtask

  task automatic test_r_type;
    fetch(OP_RTYPE, F_ADD, 2);
    nxt();
    total++;
    if (ctl !== E_EXR) begin
      bad++;
      $display("FAIL r_exe got=%h exp=%h", ctl, E_EXR);
    end
    nxt();
    total++;
    if (ctl !== E_WBR) begin
      bad++;
      $display("FAIL r_wb got=%h exp=%h", ctl, E_WBR);
    end
    nxt();
  endtask

  task automatic test_ext;
    fetch(OP_ORI, 6'h00, 0);
    total++;
    if (ExtCtrl !== 1'b0) begin
      bad++;
      $display("FAIL ori_id_ext got=%b exp=0", ExtCtrl);
    end
    nxt();
    total++;
    if ({ctl, ExtCtrl} !== {E_EXI_OR, 1'b0}) begin
      bad++;
      $display("FAIL ori_exe got=%h/%b exp=%h/0", ctl, ExtCtrl, E_EXI_OR);
    end
    nxt();
    total++;
    if ({ctl, ExtCtrl} !== {E_WBI, 1'b0}) begin
      bad++;
      $display("FAIL ori_wb got=%h/%b exp=%h/0", ctl, ExtCtrl, E_WBI);
    end
    nxt();
    fetch(OP_ADDI, 6'h00, 0);
    total++;
    if (ExtCtrl !== 1'b1) begin
      bad++;
      $display("FAIL addi_id_ext got=%b exp=1", ExtCtrl);
    end
    nxt();
    total++;
    if ({ctl, ExtCtrl} !== {E_EXI_ADD, 1'b1}) begin
      bad++;
      $display("FAIL addi_exe got=%h/%b exp=%h/1", ctl, ExtCtrl, E_EXI_ADD);
    end
    nxt();
    total++;
    if ({ctl, ExtCtrl} !== {E_WBI, 1'b1}) begin
      bad++;
      $display("FAIL addi_wb got=%h/%b exp=%h/1", ctl, ExtCtrl, E_WBI);
    end
    nxt();
  endtask

  task automatic test_lw_wait;
    fetch(OP_LW, 6'h00, 0);
    nxt();
    total++;
    if (ctl !== E_EXMA) begin
      bad++;
      $display("FAIL lw_ma got=%h exp=%h", ctl, E_EXMA);
    end
    nxt();
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      #1;
      total++;
      if (ctl !== E_MRD) begin
        bad++;
        $display("FAIL lw_mem%0d got=%h exp=%h", i, ctl, E_MRD);
      end
      nxt();
    end
    mem_ready = 1'b0;
    #1;
    total++;
    if (ctl !== E_WBLD) begin
      bad++;
      $display("FAIL lw_wb got=%h exp=%h", ctl, E_WBLD);
    end
    nxt();
  endtask

  task automatic test_sw;
    fetch(OP_SW, 6'h00, 0);
    nxt();
    nxt();
    mem_ready = 1'b1;
    #1;
    total++;
    if (ctl !== E_MWR) begin
      bad++;
      $display("FAIL sw_mem got=%h exp=%h", ctl, E_MWR);
    end
    nxt();
  endtask

  task automatic br_case(input logic [5:0] op,
                         input logic z,
                         input logic [17:0] exp);
    fetch(op, 6'h00, 0);
    nxt();
    zero = z;
    #1;
    total++;
    if (ctl !== exp) begin
      bad++;
      $display("FAIL br op=%h z=%b got=%h exp=%h", op, z, ctl, exp);
    end
    nxt();
    zero = 1'b0;
  endtask

  task automatic test_branch_jump;
    br_case(OP_BEQ, 1'b1, E_BR_T);
    br_case(OP_BNE, 1'b1, E_BR_N);
    br_case(OP_BEQ, 1'b0, E_BR_N);
    br_case(OP_BNE, 1'b0, E_BR_T);
    br_case(OP_JAL, 1'b0, E_JAL);
    br_case(OP_J,   1'b1, E_J);
  endtask

  task automatic test_illegal;
    mem_ready = 1'b1;
    #1;
    nxt();
    opcode = 6'h3E;
    mem_ready = 1'b0;
    #1;
    total++;
    if ({ctl, illegal} !== {E_ID, 1'b1}) begin
      bad++;
      $display("FAIL ill_id got=%h/%b exp=%h/1", ctl, illegal, E_ID);
    end
    nxt();
    mem_ready = 1'b1;
    #1;
    total++;
    if ({ctl, illegal} !== {E_IF_R, 1'b0}) begin
      bad++;
      $display("FAIL ill_back got=%h/%b exp=%h/0", ctl, illegal, E_IF_R);
    end
  endtask

  task automatic test_reset_mid;
    fetch(OP_SW, 6'h00, 0);
    nxt();
    nxt();
    mem_ready = 1'b0;
    #1;
    total++;
    if (ctl !== E_MWR) begin
      bad++;
      $display("FAIL mid_mem got=%h exp=%h", ctl, E_MWR);
    end
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (ctl !== E_ZERO) begin
      bad++;
      $display("FAIL mid_rst got=%h exp=%h", ctl, E_ZERO);
    end
    nxt();
    rst_n = 1'b1;
    mem_ready = 1'b1;
    #1;
    total++;
    if (ctl !== E_IF_R) begin
      bad++;
      $display("FAIL mid_if got=%h exp=%h", ctl, E_IF_R);
    end
  endtask

  task automatic test_timeout;
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b0;
      #1;
      total++;
      if ({ctl, halted, fault} !== {E_IF_W, 2'b00}) begin
        bad++;
        $display("FAIL to_wait%0d got=%h/%b%b", i, ctl, halted, fault);
      end
      nxt();
    end
    total++;
    if ({ctl, halted, fault} !== {E_ZERO, 2'b11}) begin
      bad++;
      $display("FAIL to_halt got=%h/%b%b exp=%h/11", ctl, halted, fault, E_ZERO);
    end
    mem_ready = 1'b1;
    repeat (3) nxt();
    total++;
    if ({ctl, halted, fault} !== {E_ZERO, 2'b11}) begin
      bad++;
      $display("FAIL to_sticky got=%h/%b%b exp=%h/11", ctl, halted, fault, E_ZERO);
    end
  endtask

  task automatic test_halt_op;
    fetch(OP_HALT, 6'h00, 0);
    nxt();
    total++;
    if ({ctl, halted, fault} !== {E_ZERO, 2'b10}) begin
      bad++;
      $display("FAIL halt_op got=%h/%b%b exp=%h/10", ctl, halted, fault, E_ZERO);
    end
    mem_ready = 1'b1;
    repeat (2) nxt();
    total++;
    if ({ctl, halted, fault} !== {E_ZERO, 2'b10}) begin
      bad++;
      $display("FAIL halt_hold got=%h/%b%b exp=%h/10", ctl, halted, fault, E_ZERO);
    end
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_ext();
    test_lw_wait();
    test_sw();
    test_branch_jump();
    test_illegal();
    test_reset_mid();
    test_timeout();
    test_reset();
    test_halt_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
